// File: rtl/lstm_pkg.sv
// Shared types for the LSTM buffer read path: read-initiator FSM states and
// the FIFO credit check used when deciding whether a read may be issued.
package lstm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rd_state_t;

    // A new read is allowed only if its word is guaranteed a FIFO slot,
    // counting the word already in flight and a pop happening this cycle.
    function automatic logic credit_ok(input logic [1:0] fifo_count,
                                       input logic       inflight,
                                       input logic       pop);
        return ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/mem_rd_stream_if.sv
// Bundle for one buffer read path: control (start/base/len/busy/done), the
// single-cycle-latency memory read port, and the outgoing valid/ready stream.
interface mem_rd_stream_if #(
    parameter int DWIDTH  = 16,
    parameter int MEMSIZE = 8
);
    logic                     start;
    logic [MEMSIZE-1:0]       base;
    logic [MEMSIZE:0]         len;
    logic                     busy;
    logic                     done;
    logic [MEMSIZE-1:0]       mem_addr;
    logic signed [DWIDTH-1:0] mem_rdata;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DWIDTH-1:0] out_data;
    logic                     out_last;

    modport master (
        input  start, base, len, mem_rdata, out_ready,
        output busy, done, mem_addr, out_valid, out_data, out_last
    );

    modport slave (
        output start, base, len, mem_rdata, out_ready,
        input  busy, done, mem_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mem_rd_stream_fifo2.sv
// Two-entry synchronous FIFO holding read data until the consumer takes it.
// Storage is cleared on reset so the head reads as zero until the first push.
module fifo2 #(
    parameter int DWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic signed [DWIDTH-1:0] push_data,
    output logic signed [DWIDTH-1:0] head,
    output logic [1:0]               count
);
    logic signed [DWIDTH-1:0] data_q [2];
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q[gi] <= '0;
            end else if (push && (wr_ptr_q == 1'(gi))) begin
                data_q[gi] <= push_data;
            end
        end
    end

    assign head  = data_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/mem_rd_stream.sv
// Streams len consecutive words starting at base out of a one-cycle-latency
// read port, with credit-based issue so the 2-entry FIFO can never overflow.
module mem_rd_stream
    import lstm_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int MEMSIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    mem_rd_stream_if.master bus
);
    localparam logic [MEMSIZE:0] LEN_ONE = (MEMSIZE+1)'(1);

    rd_state_t                state_q, state_d;
    logic [MEMSIZE-1:0]       addr_q, addr_d;
    logic [MEMSIZE-1:0]       mem_addr_q, mem_addr_d;
    logic [MEMSIZE:0]         issue_left_q, issue_left_d;
    logic [MEMSIZE:0]         pop_left_q, pop_left_d;
    logic                     inflight_q, inflight_d;
    logic                     done_q, done_d;

    logic [1:0]               fifo_count;
    logic signed [DWIDTH-1:0] fifo_head;
    logic                     out_valid;
    logic                     pop;
    logic                     issue;

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & bus.out_ready;
    assign issue     = (state_q == RUN) && (issue_left_q != '0)
                       && credit_ok(fifo_count, inflight_q, pop);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        pop_left_d   = pop_left_q;
        done_d       = 1'b0;
        inflight_d   = issue;
        // The port keeps its last address when idle; those reads are dropped.
        mem_addr_d   = issue ? addr_q : mem_addr_q;

        if (pop) pop_left_d = pop_left_q - LEN_ONE;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d       = bus.base;
                        issue_left_d = bus.len;
                        pop_left_d   = bus.len;
                        state_d      = RUN;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d       = addr_q + 1'b1;
                    issue_left_d = issue_left_q - LEN_ONE;
                    if (issue_left_q == LEN_ONE) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && (pop_left_q == LEN_ONE)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            mem_addr_q   <= '0;
            issue_left_q <= '0;
            pop_left_q   <= '0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            mem_addr_q   <= mem_addr_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            inflight_q   <= inflight_d;
            done_q       <= done_d;
        end
    end

    fifo2 #(.DWIDTH(DWIDTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .pop       (pop),
        .push_data (bus.mem_rdata),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.mem_addr  = mem_addr_d;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = fifo_head;
    assign bus.out_last  = out_valid && (pop_left_q == LEN_ONE);
endmodule

// File: tb/tb_mem_rd_stream.sv
// Scoreboard bench for mem_rd_stream: expected words queued at start, checked
// on every stream pop, plus timing, backpressure, len=0 and reset scenarios.
module tb_mem_rd_stream;
    localparam int DW = 16;
    localparam int MS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_rd_stream_if #(.DWIDTH(DW), .MEMSIZE(MS)) bus ();

    mem_rd_stream #(.DWIDTH(DW), .MEMSIZE(MS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic signed [DW-1:0] data;
        logic                 last;
    } exp_t;

    exp_t                 sb[$];
    logic signed [DW-1:0] mem [256];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    int rdy_mode = 1;
    int first_pop_cyc = -1;
    int last_pop_cyc  = -1;
    int done_cyc      = -1;
    int valid_cnt     = 0;
    bit done_seen     = 0;
    bit stall_prev    = 0;
    logic signed [DW-1:0] data_prev = '0;
    logic                 last_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, $signed(got), $signed(exp), cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Single-cycle-latency memory model
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("valid_hold", 32'(bus.out_valid), 32'd1);
                chk("data_hold", 32'(bus.out_data), 32'(data_prev));
                chk("last_hold", 32'(bus.out_last), 32'(last_prev));
            end
            if (bus.out_valid) valid_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_word", 32'(bus.out_data), 32'hDEAD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("[TB] pop data=%0d last=%0d exp=%0d/%0d", bus.out_data, bus.out_last, e.data, e.last);
                    chk("data", 32'(bus.out_data), 32'(e.data));
                    chk("last", 32'(bus.out_last), 32'(e.last));
                end
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                if (bus.out_last) last_pop_cyc = cyc;
            end
            if (bus.done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                chk("busy_at_done", 32'(bus.busy), 32'd0);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            data_prev  = bus.out_data;
            last_prev  = bus.out_last;
        end
    end

    task automatic start_xfer(input int b, input int l);
        exp_t e;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.base  = MS'(b);
        bus.len   = (MS+1)'(l);
        t0 = cyc;
        first_pop_cyc = -1;
        last_pop_cyc  = -1;
        done_cyc      = -1;
        done_seen     = 1'b0;
        for (int i = 0; i < l; i++) begin
            e.data = mem[(b + i) % 256];
            e.last = (i == l - 1);
            sb.push_back(e);
        end
        $display("[TB] start base=%0d len=%0d", b, l);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && !done_seen; i++) @(posedge clk);
        chk("done_seen", 32'(done_seen), 32'd1);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
        chk({tag, "_done"},      32'(bus.done),      32'd0);
        chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
        chk({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    endtask

    initial begin
        int vc;
        for (int i = 0; i < 256; i++) mem[i] = DW'(i - 100);
        bus.start = 1'b0;
        bus.base  = '0;
        bus.len   = '0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic transfer with fixed latency checks
        rdy_mode = 1;
        start_xfer(4, 5);
        wait_done();
        chk("first_word_cycle", 32'(first_pop_cyc - t0), 32'd3);
        chk("last_word_cycle",  32'(last_pop_cyc - t0),  32'd7);
        chk("done_cycle",       32'(done_cyc - t0),      32'd8);
        chk("sb_empty_basic",   32'(sb.size()),          32'd0);

        // Address wrap 254,255,0,1
        start_xfer(254, 4);
        wait_done();
        chk("sb_empty_wrap", 32'(sb.size()), 32'd0);

        // Random backpressure
        rdy_mode = 2;
        start_xfer(30, 16);
        wait_done();
        chk("sb_empty_bp", 32'(sb.size()), 32'd0);

        // len = 0
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        vc = valid_cnt;
        start_xfer(7, 0);
        chk("len0_busy", 32'(bus.busy), 32'd0);
        wait_done();
        chk("len0_done_cycle", 32'(done_cyc - t0), 32'd1);
        repeat (3) @(posedge clk);
        chk("len0_no_valid", 32'(valid_cnt - vc), 32'd0);

        // start while busy is ignored
        rdy_mode = 2;
        start_xfer(20, 6);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.base  = MS'(100);
        bus.len   = (MS+1)'(3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done();
        chk("sb_empty_midstart", 32'(sb.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("midstart_idle", 32'(bus.busy), 32'd0);

        // Reset in FLUSH with the consumer stalled
        rdy_mode = 0;
        start_xfer(50, 2);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy",  32'(bus.busy),      32'd1);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("held_rst");
        rst = 1'b0;
        rdy_mode = 1;
        start_xfer(10, 3);
        wait_done();
        chk("post_rst_first_cycle", 32'(first_pop_cyc - t0), 32'd3);
        chk("post_rst_done_cycle",  32'(done_cyc - t0),      32'd6);
        chk("sb_empty_post_rst",    32'(sb.size()),          32'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_rd_stream.md
# mem_rd_stream

Read-side initiator for the single-cycle-latency, read-only memory port used by the LSTM weight and state buffers. It walks `len` consecutive words from `base`, drives the port address, absorbs the one-cycle read latency, and presents the words as a valid/ready stream to the datapath with full backpressure support. One instance sits between each buffer read port and its consuming MAC or activation stage.

## Interface
- `DWIDTH`, 16, word width, signed
- `MEMSIZE`, 8, address width; the memory holds 2**MEMSIZE words
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base`  in  MEMSIZE  first word address; latched on accepted `start`
- `len`  in  MEMSIZE+1  word count, 0..2**MEMSIZE; latched on accepted `start`
- `busy`  out  1  high whenever the FSM is not in IDLE
- `done`  out  1  one-cycle pulse when the transfer completes
- `mem_addr`  out  MEMSIZE  memory read address; the memory registers it on every `clk` edge
- `mem_rdata`  in  DWIDTH  signed; equals `mem[address registered at the previous edge]`
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  consumer accepts the word
- `out_data`  out  DWIDTH  signed stream word
- `out_last`  out  1  qualifies the final word of the transfer

## Operation
- FSM states: IDLE, RUN, FLUSH.
- IDLE + `start`, `len`≠0: latch `base` into the address counter, latch `len` into `issue_left` and `pop_left`, go to RUN.
- IDLE + `start`, `len`=0: stay in IDLE, pulse `done` on the next cycle, issue no reads.
- `start` while `busy` is ignored.
- Issue condition in RUN: `issue_left`≠0 and `fifo_count + inflight − pop` < 2. `pop` = `out_valid & out_ready` in the current cycle.
- Issue action: `mem_addr` = address counter, counter increments modulo 2**MEMSIZE (wraps 2**MEMSIZE−1 → 0), `issue_left` decrements, and the `inflight` flag is set for the next cycle.
- A cycle with `inflight` set pushes `mem_rdata` into the 2-entry FIFO. There is no other path into the FIFO.
- `mem_addr` holds its last value when not issuing; the resulting reads are discarded because `inflight` is 0.
- RUN → FLUSH when the last address is issued.
- FLUSH → IDLE on the pop that takes `pop_left` from 1 to 0. `done` pulses in the following cycle.
- Stream output: `out_valid` = FIFO not empty; `out_data` = FIFO head. `out_last` = `out_valid & (pop_left == 1)`.
- Stream rules: `out_data` and `out_last` are stable while `out_valid & !out_ready`; `out_valid` never drops without a pop.
- FIFO invariant: `fifo_count + inflight` ≤ 2 at all times, so the FIFO can never overflow.
- Reset (any cycle, including mid-transfer): state IDLE, FIFO emptied, `inflight` = 0, all counters cleared. Every output is 0 during and after reset until a new `start`: `busy`, `done`, `mem_addr`, `out_valid`, `out_data`, `out_last`.

## Timing
- `start` in cycle 0 → RUN and first `mem_addr` in cycle 1 → `mem_rdata` valid in cycle 2 (FIFO push) → `out_valid` in cycle 3.
- With `out_ready` held high, throughput is 1 word/cycle. The last word appears in cycle `len`+2, `done` in cycle `len`+3, `busy` low from cycle `len`+3.
- `len`=0: `done` in cycle 1; `busy` never rises.
- Backpressure: after `out_ready` falls, at most one more address is issued, then issue stalls. Issue resumes in the same cycle that a pop frees a slot.
- Simultaneous push and pop in one cycle: the FIFO count is unchanged.

## Structure
- Shared package `lstm_pkg`: state enum `rd_state_t` {IDLE, RUN, FLUSH}.
- Sub-module `fifo2`: 2-entry synchronous FIFO, parameterised on `DWIDTH`, with push, pop, head, count, and async reset.
- Top level holds the FSM, the address and length counters, the `inflight` flag, and the credit logic.

## Test plan
- Memory preloaded with `mem[i]=i−100`; `base`=4, `len`=5, `out_ready`=1 → `out_data` −96..−92 in cycles 3..7; `out_last` in cycle 7; `done` in cycle 8.
- Wrap: MEMSIZE=8, `base`=254, `len`=4 → addresses 254, 255, 0, 1 in order; data matches.
- Backpressure: `out_ready` toggles 1,0,0,1,… (random pattern) over `len`=16 → all 16 words delivered in order, none duplicated or lost; `fifo_count` never exceeds 2; `out_data` stable while stalled.
- `len`=0 → `done` one cycle after `start`; no `out_valid`; `busy` stays 0.
- `start` pulsed mid-transfer → ignored; the original transfer completes unchanged.
- `rst` asserted in FLUSH with `out_ready`=0 → all outputs 0 immediately; a new `start` after release behaves as a fresh transfer.
